// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a FIFO and serialises them as UART frames (start, data LSB first, stop).
// Defining FIFO_UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module fifo_uart_tx #(
  parameter int WordLength = 8,
  parameter int ClkDiv = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tx_en_i,
  input  logic [WordLength-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int BW = $clog2(ClkDiv);
  localparam int NW = $clog2(WordLength);
`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif
  state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [NW-1:0] bit_q, bit_d;
  logic [WordLength-1:0] shift_q, shift_d;
  logic tx_q, tx_d, baud_last, bit_last, pop;
  assign baud_last = baud_q == BW'(ClkDiv - 1);
  assign bit_last = bit_q == NW'(WordLength - 1);
  // Reset gating keeps the pop strobe low while the block is held in reset.
  assign pop = rst_ni && !fifo_empty_i && tx_en_i && (state_q == IDLE || (state_q == STOP && baud_last));
  assign fifo_rd_o = pop;
  assign tx_o = tx_q;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == STOP && baud_last;
`ifdef FIFO_UART_TX_PARITY_EN
  logic par_q, par_d;
  assign par_d = pop ? ^fifo_data_i : par_q;
`endif
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    baud_d = (state_q == IDLE || baud_last) ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE:  state_d = pop ? START : IDLE;
      START: state_d = baud_last ? DATA : START;
      DATA: if (baud_last) begin
        shift_d = shift_q >> 1;
        bit_d = bit_last ? '0 : bit_q + 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
        state_d = bit_last ? PARITY : DATA;
`else
        state_d = bit_last ? STOP : DATA;
`endif
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: state_d = baud_last ? STOP : PARITY;
`endif
      STOP:  state_d = baud_last ? (pop ? START : IDLE) : STOP;
      default: state_d = IDLE;
    endcase
    if (pop) shift_d = fifo_data_i;
    // tx is driven from the next state so the line changes on the same edge as the state.
`ifdef FIFO_UART_TX_PARITY_EN
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_q : 1'b1;
`else
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`endif
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
    end
  end
`ifdef FIFO_UART_TX_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) par_q <= 1'b0;
    else par_q <= par_d;
  end
`endif
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: frame-timer reference model checked every cycle, plus literal frame checks.
module tb_fifo_uart_tx;
  localparam int WL = 8;
  localparam int CD = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = WL + 3;
`else
  localparam int NB = WL + 2;
`endif
  localparam int F = NB * CD;
  logic clk = 0, rst_n = 1, tx_en = 0, fifo_empty = 1;
  logic fifo_rd, tx, busy, done;
  logic [WL-1:0] fifo_data = '0;
  logic [WL-1:0] q[$];
  int rd_hist[$];
  int nvec = 0, nerr = 0, cyc = 0, done_cyc = -1, done_cnt = 0;
  bit m_act = 0, pop_pend = 0;
  int m_t = 0;
  logic [WL-1:0] m_word = '0;
  logic tx_log[0:4095];
  always #5 clk = ~clk;
  fifo_uart_tx #(.WordLength(WL), .ClkDiv(CD)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tx_en_i(tx_en), .fifo_data_i(fifo_data),
    .fifo_empty_i(fifo_empty), .fifo_rd_o(fifo_rd), .tx_o(tx), .busy_o(busy), .done_o(done)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask
  function automatic logic m_tx();
    int k = m_t / CD;
    if (!m_act) return 1'b1;
    if (k == 0) return 1'b0;
    if (k <= WL) return m_word[k-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (k == WL + 1) return ^m_word;
`endif
    return 1'b1;
  endfunction
  function automatic logic txl(int i);
    return (i >= 0 && i < 4096) ? tx_log[i] : 1'bx;
  endfunction
  function automatic int last_rd();
    return rd_hist.size() > 0 ? rd_hist[rd_hist.size()-1] : -1000;
  endfunction
  task automatic compare();
    logic e_rd;
    if (!rst_n) m_act = 0;
    e_rd = rst_n && !fifo_empty && tx_en && (!m_act || m_t == F - 1);
    chk("tx", tx, m_tx());
    chk("busy", busy, m_act);
    chk("done", done, m_act && m_t == F - 1);
    chk("rd", fifo_rd, e_rd);
    if (cyc < 4096) tx_log[cyc] = tx;
    if (fifo_rd) rd_hist.push_back(cyc);
    if (done) begin done_cyc = cyc; done_cnt++; end
    pop_pend = fifo_rd;
    if (e_rd) begin m_act = 1; m_t = 0; m_word = fifo_data; end
    else if (m_act) begin
      if (m_t == F - 1) m_act = 0;
      else m_t++;
    end
  endtask
  task automatic refresh();
    fifo_empty = q.size() == 0;
    fifo_data = q.size() > 0 ? q[0] : '0;
  endtask
  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      compare();
      @(posedge clk);
      #1;
      if (pop_pend && q.size() > 0) void'(q.pop_front());
      refresh();
      cyc++;
    end
  endtask
  task automatic push(logic [WL-1:0] w);
    q.push_back(w);
    refresh();
  endtask
  initial begin
    int r1, r2, n0, c;
    logic [9:0] a5_bits;
    logic [WL-1:0] w;
    a5_bits = 10'b1101001010;
    #1 rst_n = 0;
    step(3);
    rst_n = 1;
    step(100);
    chk("idle_no_pop", rd_hist.size(), 0);
    chk("idle_tx", tx, 1);
    // single frame of 0xA5
    tx_en = 1;
    push(8'hA5);
    step(F + 6);
    chk("single_pops", rd_hist.size(), 1);
    r1 = last_rd();
    chk("single_done_at", done_cyc - r1, F);
    for (int k = 0; k < 9; k++) chk("a5_bit", txl(r1 + 1 + CD * k), a5_bits[k]);
    chk("a5_stop", txl(r1 + 1 + CD * (NB - 1)), 1);
`ifdef FIFO_UART_TX_PARITY_EN
    chk("a5_parity", txl(r1 + 1 + CD * (WL + 1)), 0);
`endif
    chk("single_busy_end", busy, 0);
    // back-to-back 0x00 then 0xFF
    n0 = rd_hist.size();
    push(8'h00);
    push(8'hFF);
    step(2 * F + 6);
    chk("b2b_pops", rd_hist.size() - n0, 2);
    r1 = rd_hist[n0];
    r2 = last_rd();
    chk("b2b_period", r2 - r1, F);
    chk("b2b_total", done_cyc - r1, 2 * F);
    chk("b2b_no_gap", txl(r2 + 1), 0);
    chk("b2b_ff_bit0", txl(r2 + 1 + CD), 1);
    // enable gating
    n0 = rd_hist.size();
    push(8'h3C);
    push(8'h81);
    push(8'h5A);
    step(14);
    tx_en = 0;
    step(F + 20);
    chk("gate_one_pop", rd_hist.size() - n0, 1);
    chk("gate_left", q.size(), 2);
    chk("gate_tx_idle", tx, 1);
    c = cyc;
    tx_en = 1;
    step(1);
    chk("gate_resume_cyc", last_rd(), c);
    step(2);
    chk("gate_start_low", tx, 0);
    step(2 * F + 6);
    chk("gate_all_sent", q.size(), 0);
    // reset in the middle of data bit 3
    n0 = rd_hist.size();
    push(8'h96);
    push(8'h4B);
    step(1);
    step(17);
    rst_n = 0;
    #1;
    chk("rst_tx_now", tx, 1);
    chk("rst_busy_now", busy, 0);
    chk("rst_rd_now", fifo_rd, 0);
    step(2);
    rst_n = 1;
    step(F + 10);
    chk("rst_pops", rd_hist.size() - n0, 2);
    chk("rst_q_empty", q.size(), 0);
    r2 = last_rd();
    w = 8'h4B;
    for (int k = 0; k < WL; k++) chk("after_rst_bit", txl(r2 + 1 + CD * (k + 1)), w[k]);
`ifdef FIFO_UART_TX_PARITY_EN
    push(8'hA5);
    step(F + 4);
    r1 = last_rd();
    chk("par_a5", txl(r1 + 1 + CD * (WL + 1)), 0);
    chk("par_len", done_cyc - r1, 44);
    push(8'h07);
    step(F + 4);
    r1 = last_rd();
    chk("par_07", txl(r1 + 1 + CD * (WL + 1)), 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
